memory_access_stage: RTL and testbench
======================================

// Module: memory_access_stage
// PURPOSE
//  MEM pipeline stage; consumes the EX/MEM pipeline register outputs, drives the data-memory port.
//  Performs byte/half/word load-store alignment per func3 and sign/zero extension of loads.
//  Runs a request/ready handshake FSM and stalls upstream while an access is outstanding.
//  Registers MEM/WB results: write-back data, rd, write enable.
// PARAMETERS
//  TIMEOUT_CYCLES  255  max BUSY cycles waiting for dmemReady before abort with fault
//  COUNT_WIDTH     8    width of wait counter; must hold TIMEOUT_CYCLES
// PORTS
//  clock                     in   1   single clock, rising edge
//  reset                     in   1   asynchronous, active-low reset (0 = reset)
//  pcAdder                   in   32  PC+4 from EX/MEM
//  alu                       in   32  ALU result / effective address from EX/MEM
//  readData2                 in   32  store data from EX/MEM
//  func3                     in   3   access size/sign from EX/MEM
//  memoryReadEnable          in   1   load
//  memoryWriteEnable         in   1   store
//  writeBackFromMemoryOrAlu  in   1   1 = write back load data, 0 = alu
//  registerWriteEnable       in   1   from EX/MEM
//  rd                        in   5   from EX/MEM
//  dmemRequest               out  1   request valid, held until dmemReady
//  dmemWrite                 out  1   1 = store, 0 = load
//  dmemAddress               out  32  {alu[31:2],2'b00}
//  dmemWriteData             out  32  store data lane-replicated
//  dmemByteEnable            out  4   active byte lanes
//  dmemReadData              in   32  word read data, valid with dmemReady
//  dmemReady                 in   1   completes request this cycle
//  stall                     out  1   freeze PC/IF/ID/ID-EX/EX-MEM registers
//  writeBackDataOut          out  32  MEM/WB data
//  rdOut                     out  5   MEM/WB rd
//  registerWriteEnableOut    out  1   MEM/WB write enable
//  faultOut                  out  1   one-cycle pulse: misaligned/illegal/timeout
// BEHAVIOUR
//  Reset (async, reset=0): FSM IDLE, counter 0, all registered outputs 0; dmemRequest drops at once.
//  access = memoryReadEnable|memoryWriteEnable. Both set at once = illegal.
//  Illegal: func3 not in {000,001,010,100,101} for load, {000,001,010} for store.
//  Misaligned: half with alu[0]=1; word with alu[1:0]!=0.
//  Illegal/misaligned in IDLE: no request, stall=0, next edge registerWriteEnableOut=0, faultOut=1.
//  FSM IDLE: valid access -> stall=1, latch addr/data/func3/rd/ctrl, -> BUSY; MEM/WB gets bubble.
//  FSM BUSY: dmemRequest=1 with latched fields (stable); stall=!dmemReady; counter++ per cycle.
//   dmemReady=1 -> capture result into MEM/WB, -> IDLE, counter cleared.
//   counter reaches TIMEOUT_CYCLES without ready -> drop request, bubble, faultOut=1, -> IDLE, stall=0.
//  Ready and timeout same cycle: ready wins.
//  Non-access instr: no request, stall=0; MEM/WB registers alu or pcAdder path unchanged (1-cycle).
//  Min load/store occupancy 2 cycles (IDLE detect + BUSY with ready); latency 1 + wait cycles.
//  Any stall=1 cycle: MEM/WB loads bubble (registerWriteEnableOut=0); no duplicate writes.
//  Store lanes: SB en=4'b0001<<alu[1:0], data={4{b}}; SH en=4'b0011<<{alu[1],1'b0}, data={2{h}}; SW 4'hF.
//  Load extract: byte at alu[1:0], half at alu[1]; LB/LH sign-extend, LBU/LHU zero-extend, LW as-is.
//  writeBackDataOut = writeBackFromMemoryOrAlu ? extracted load : alu.
//  Store completes with registerWriteEnableOut=0 regardless of input.
//  rd=0: forward as given; regfile ignores x0 writes.
// TESTING
//  LW alu=0x100, ready after 3 BUSY cycles, data 0xDEADBEEF -> stall 4 cycles, then wb=0xDEADBEEF, we=1.
//  LB alu=0x103, data 0x80AABBCC -> wb=0xFFFFFF80; LBU same -> 0x00000080; LHU alu=0x102 -> 0x000080AA.
//  SB alu=0x201, rs2=0x000000A5 -> en=4'b0010, wdata=0xA5A5A5A5, dmemWrite=1, we out=0.
//  SW alu=0x202 -> no request, stall=0, faultOut pulse, we out=0; LH alu=0x101 same response.
//  Load, ready never asserted, TIMEOUT_CYCLES=4 -> request for 4 BUSY cycles, then fault, stall=0, IDLE.
//  reset=0 mid-BUSY -> dmemRequest/stall fall immediately, all outputs 0; after release ALU op passes 1 cycle.

Source files
------------

// File: rtl/memory_access_stage.sv
// MEM pipeline stage: aligns loads/stores, runs the data-memory request/ready
// handshake with a timeout, stalls upstream while busy and registers MEM/WB results.
module memory_access_stage #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned COUNT_WIDTH    = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] pcAdder,
  input  logic [31:0] alu,
  input  logic [31:0] readData2,
  input  logic [2:0]  func3,
  input  logic        memoryReadEnable,
  input  logic        memoryWriteEnable,
  input  logic        writeBackFromMemoryOrAlu,
  input  logic        registerWriteEnable,
  input  logic [4:0]  rd,
  output logic        dmemRequest,
  output logic        dmemWrite,
  output logic [31:0] dmemAddress,
  output logic [31:0] dmemWriteData,
  output logic [3:0]  dmemByteEnable,
  input  logic [31:0] dmemReadData,
  input  logic        dmemReady,
  output logic        stall,
  output logic [31:0] writeBackDataOut,
  output logic [4:0]  rdOut,
  output logic        registerWriteEnableOut,
  output logic        faultOut
);

  typedef enum logic {S_IDLE = 1'b0, S_BUSY = 1'b1} state_t;

  localparam logic [COUNT_WIDTH-1:0] W_LAST = COUNT_WIDTH'(TIMEOUT_CYCLES - 1);

  state_t                 r_state, w_next_state;
  logic [COUNT_WIDTH-1:0] r_count;
  logic [31:0]            r_addr, r_wdata;
  logic [3:0]             r_be;
  logic [2:0]             r_func3;
  logic [4:0]             r_rd;
  logic                   r_write, r_wb_sel, r_reg_we;

  logic        w_access, w_illegal, w_misaligned, w_start, w_timeout;
  logic [3:0]  w_be;
  logic [31:0] w_wdata, w_load;
  logic [15:0] w_lane;
  logic        w_unused_pc;

  // PC+4 selection happens upstream of this stage; the input is kept for port compatibility.
  assign w_unused_pc = ^pcAdder;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    w_access     = memoryReadEnable | memoryWriteEnable;
    w_illegal    = 1'b0;
    if (memoryReadEnable && memoryWriteEnable)
      w_illegal = 1'b1;
    else if (memoryWriteEnable)
      w_illegal = func3[2] | (func3[1:0] == 2'b11);
    else if (memoryReadEnable)
      w_illegal = (func3[1:0] == 2'b11) | (func3 == 3'b110);
    w_misaligned = ((func3[1:0] == 2'b01) && alu[0]) ||
                   ((func3[1:0] == 2'b10) && (alu[1:0] != 2'b00));
  end

  always_comb begin
    w_be    = 4'hF;
    w_wdata = readData2;
    case (func3[1:0])
      2'b00: begin
        w_be    = 4'b0001 << alu[1:0];
        w_wdata = {4{readData2[7:0]}};
      end
      2'b01: begin
        w_be    = 4'b0011 << {alu[1], 1'b0};
        w_wdata = {2{readData2[15:0]}};
      end
      default: ;
    endcase
  end

  // Accesses are aligned, so one shift by the byte offset serves both byte and half lanes.
  assign w_lane = 16'(dmemReadData >> {r_addr[1:0], 3'b000});

  always_comb begin
    case (r_func3)
      3'b000:  w_load = {{24{w_lane[7]}}, w_lane[7:0]};
      3'b100:  w_load = {24'd0, w_lane[7:0]};
      3'b001:  w_load = {{16{w_lane[15]}}, w_lane};
      3'b101:  w_load = {16'd0, w_lane};
      default: w_load = dmemReadData;
    endcase
  end

  always_comb begin
    w_next_state = r_state;
    w_start      = 1'b0;
    w_timeout    = 1'b0;
    stall        = 1'b0;
    dmemRequest  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (reset && w_access && !w_illegal && !w_misaligned) begin
          w_start      = 1'b1;
          stall        = 1'b1;
          w_next_state = S_BUSY;
        end
      end
      S_BUSY: begin
        dmemRequest = 1'b1;
        if (dmemReady) begin
          w_next_state = S_IDLE;
        end else if (r_count == W_LAST) begin
          w_timeout    = 1'b1;
          w_next_state = S_IDLE;
        end else begin
          stall = 1'b1;
        end
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_count <= '0;
    end else begin
      r_state <= w_next_state;
      if (r_state == S_BUSY && w_next_state == S_BUSY)
        r_count <= r_count + COUNT_WIDTH'(1);
      else
        r_count <= '0;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_addr   <= '0;
      r_wdata  <= '0;
      r_be     <= '0;
      r_func3  <= '0;
      r_rd     <= '0;
      r_write  <= 1'b0;
      r_wb_sel <= 1'b0;
      r_reg_we <= 1'b0;
    end else if (w_start) begin
      r_addr   <= alu;
      r_wdata  <= w_wdata;
      r_be     <= w_be;
      r_func3  <= func3;
      r_rd     <= rd;
      r_write  <= memoryWriteEnable;
      r_wb_sel <= writeBackFromMemoryOrAlu;
      r_reg_we <= registerWriteEnable & ~memoryWriteEnable;
    end
  end

  assign dmemWrite      = r_write;
  assign dmemAddress    = {r_addr[31:2], 2'b00};
  assign dmemWriteData  = r_wdata;
  assign dmemByteEnable = r_be;

  // MEM/WB: write enable defaults to a bubble; data and rd hold unless a result lands.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      writeBackDataOut       <= '0;
      rdOut                  <= '0;
      registerWriteEnableOut <= 1'b0;
      faultOut               <= 1'b0;
    end else begin
      registerWriteEnableOut <= 1'b0;
      faultOut               <= 1'b0;
      if (r_state == S_IDLE) begin
        if (!w_access) begin
          writeBackDataOut       <= alu;
          rdOut                  <= rd;
          registerWriteEnableOut <= registerWriteEnable;
        end else if (!w_start) begin
          faultOut <= 1'b1;
        end
      end else if (dmemReady) begin
        writeBackDataOut       <= r_wb_sel ? w_load : r_addr;
        rdOut                  <= r_rd;
        registerWriteEnableOut <= r_reg_we;
      end else if (w_timeout) begin
        faultOut <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_memory_access_stage.sv
// Randomized self-checking bench for memory_access_stage with a behavioural
// reference model of alignment, extension, legality and handshake timing.
module tb_memory_access_stage;

  localparam int TO = 4;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] pcAdder = '0, alu = '0, readData2 = '0, dmemReadData = '0;
  logic [2:0]  func3 = '0;
  logic        memoryReadEnable = 1'b0, memoryWriteEnable = 1'b0;
  logic        writeBackFromMemoryOrAlu = 1'b0, registerWriteEnable = 1'b0, dmemReady = 1'b0;
  logic [4:0]  rd = '0;
  logic        dmemRequest, dmemWrite, stall, registerWriteEnableOut, faultOut;
  logic [31:0] dmemAddress, dmemWriteData, writeBackDataOut;
  logic [3:0]  dmemByteEnable;
  logic [4:0]  rdOut;

  int checks = 0;
  int errors = 0;

  memory_access_stage #(.TIMEOUT_CYCLES(TO), .COUNT_WIDTH(8)) dut (
    .clock(clock), .reset(reset), .pcAdder(pcAdder), .alu(alu), .readData2(readData2),
    .func3(func3), .memoryReadEnable(memoryReadEnable), .memoryWriteEnable(memoryWriteEnable),
    .writeBackFromMemoryOrAlu(writeBackFromMemoryOrAlu),
    .registerWriteEnable(registerWriteEnable), .rd(rd),
    .dmemRequest(dmemRequest), .dmemWrite(dmemWrite), .dmemAddress(dmemAddress),
    .dmemWriteData(dmemWriteData), .dmemByteEnable(dmemByteEnable),
    .dmemReadData(dmemReadData), .dmemReady(dmemReady), .stall(stall),
    .writeBackDataOut(writeBackDataOut), .rdOut(rdOut),
    .registerWriteEnableOut(registerWriteEnableOut), .faultOut(faultOut)
  );

  always #5 clock = ~clock;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic logic m_legal(input logic ld, input logic st, input logic [2:0] f3,
                                   input logic [31:0] a);
    int nbytes;
    if (ld == st) return 1'b0;
    if (st && !(f3 inside {3'd0, 3'd1, 3'd2})) return 1'b0;
    if (ld && !(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})) return 1'b0;
    nbytes = 1 << f3[1:0];
    return (int'(a[1:0]) % nbytes) == 0;
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a,
                                         input logic [31:0] d);
    logic [31:0] v;
    logic [31:0] b;
    logic [31:0] h;
    v = d >> (8 * int'(a[1:0]));
    b = v & 32'hFF;
    h = v & 32'hFFFF;
    case (f3)
      3'd0:    return (b >= 32'd128) ? b - 32'd256 : b;
      3'd4:    return b;
      3'd1:    return (h >= 32'd32768) ? h - 32'd65536 : h;
      3'd5:    return h;
      default: return d;
    endcase
  endfunction

  function automatic logic [3:0] m_be(input logic [2:0] f3, input logic [31:0] a);
    int m;
    m = ((1 << (1 << f3[1:0])) - 1) << int'(a[1:0]);
    return m[3:0];
  endfunction

  function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] d);
    logic [31:0] w;
    int n;
    n = 1 << f3[1:0];
    for (int b = 0; b < 4; b++) w[8*b +: 8] = d[8*(b % n) +: 8];
    return w;
  endfunction

  // ---------------- scenario tasks (start and end at posedge+1) ----------------
  task automatic alu_op(input string name, input logic [31:0] a, input logic [4:0] rdv,
                        input logic rwe);
    memoryReadEnable = 1'b0; memoryWriteEnable = 1'b0;
    alu = a; rd = rdv; registerWriteEnable = rwe;
    writeBackFromMemoryOrAlu = 1'($urandom_range(0, 1));
    pcAdder = $urandom; readData2 = $urandom; func3 = 3'($urandom_range(0, 7));
    @(negedge clock);
    checks++; if (dmemRequest !== 1'b0) begin errors++; $display("FAIL %s req: got %0b exp 0", name, dmemRequest); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL %s stall: got %0b exp 0", name, stall); end
    @(posedge clock); #1;
    checks++; if (writeBackDataOut !== a) begin errors++; $display("FAIL %s wb: got %h exp %h", name, writeBackDataOut, a); end
    checks++; if (rdOut !== rdv) begin errors++; $display("FAIL %s rd: got %0d exp %0d", name, rdOut, rdv); end
    checks++; if (registerWriteEnableOut !== rwe) begin errors++; $display("FAIL %s we: got %0b exp %0b", name, registerWriteEnableOut, rwe); end
    checks++; if (faultOut !== 1'b0) begin errors++; $display("FAIL %s fault: got %0b exp 0", name, faultOut); end
  endtask

  // wait_c = BUSY cycles without ready before the ready cycle; >= TO means never ready.
  task automatic run_mem(input string name, input logic ld, input logic st, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rdat,
                         input logic [4:0] rdv, input logic wbs, input logic rwe, input int wait_c);
    logic ok, rdy, exp_stall, exp_we;
    logic [31:0] exp_wb;
    ok = m_legal(ld, st, f3, a);
    exp_we = rwe & ~st;
    exp_wb = wbs ? m_load(f3, a, rdat) : a;
    memoryReadEnable = ld; memoryWriteEnable = st; func3 = f3; alu = a; readData2 = wd;
    rd = rdv; writeBackFromMemoryOrAlu = wbs; registerWriteEnable = rwe; pcAdder = $urandom;
    dmemReady = 1'b0;
    @(negedge clock);
    checks++; if (dmemRequest !== 1'b0) begin errors++; $display("FAIL %s idle_req: got %0b exp 0", name, dmemRequest); end
    checks++; if (stall !== ok) begin errors++; $display("FAIL %s idle_stall: got %0b exp %0b", name, stall, ok); end
    @(posedge clock); #1;
    checks++; if (registerWriteEnableOut !== 1'b0) begin errors++; $display("FAIL %s bubble_we: got %0b exp 0", name, registerWriteEnableOut); end
    checks++; if (faultOut !== !ok) begin errors++; $display("FAIL %s idle_fault: got %0b exp %0b", name, faultOut, !ok); end
    if (ok) begin
      for (int k = 0; k < TO; k++) begin
        rdy = (k == wait_c);
        dmemReady = rdy;
        dmemReadData = rdy ? rdat : $urandom;
        exp_stall = !(rdy || k == TO - 1);
        @(negedge clock);
        checks++; if (dmemRequest !== 1'b1) begin errors++; $display("FAIL %s busy_req[%0d]: got %0b exp 1", name, k, dmemRequest); end
        checks++; if (stall !== exp_stall) begin errors++; $display("FAIL %s busy_stall[%0d]: got %0b exp %0b", name, k, stall, exp_stall); end
        checks++; if (dmemAddress !== (a & 32'hFFFF_FFFC)) begin errors++; $display("FAIL %s addr: got %h exp %h", name, dmemAddress, a & 32'hFFFF_FFFC); end
        checks++; if (dmemWrite !== st) begin errors++; $display("FAIL %s dwrite: got %0b exp %0b", name, dmemWrite, st); end
        if (st) begin
          checks++; if (dmemByteEnable !== m_be(f3, a)) begin errors++; $display("FAIL %s be: got %b exp %b", name, dmemByteEnable, m_be(f3, a)); end
          checks++; if (dmemWriteData !== m_wdata(f3, wd)) begin errors++; $display("FAIL %s wdata: got %h exp %h", name, dmemWriteData, m_wdata(f3, wd)); end
        end
        @(posedge clock); #1;
        if (rdy) begin
          checks++; if (registerWriteEnableOut !== exp_we) begin errors++; $display("FAIL %s done_we: got %0b exp %0b", name, registerWriteEnableOut, exp_we); end
          checks++; if (rdOut !== rdv) begin errors++; $display("FAIL %s done_rd: got %0d exp %0d", name, rdOut, rdv); end
          checks++; if (faultOut !== 1'b0) begin errors++; $display("FAIL %s done_fault: got %0b exp 0", name, faultOut); end
          if (ld) begin
            checks++; if (writeBackDataOut !== exp_wb) begin errors++; $display("FAIL %s done_wb: got %h exp %h", name, writeBackDataOut, exp_wb); end
          end
          break;
        end else if (k == TO - 1) begin
          checks++; if (faultOut !== 1'b1) begin errors++; $display("FAIL %s timeout_fault: got %0b exp 1", name, faultOut); end
          checks++; if (registerWriteEnableOut !== 1'b0) begin errors++; $display("FAIL %s timeout_we: got %0b exp 0", name, registerWriteEnableOut); end
        end else begin
          checks++; if (registerWriteEnableOut !== 1'b0 || faultOut !== 1'b0) begin errors++; $display("FAIL %s wait_out[%0d]: got we=%0b fault=%0b exp 0/0", name, k, registerWriteEnableOut, faultOut); end
        end
      end
      dmemReady = 1'b0;
    end
    memoryReadEnable = 1'b0; memoryWriteEnable = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    checks++; if ({dmemRequest, stall, registerWriteEnableOut, faultOut} !== 4'b0) begin errors++; $display("FAIL reset_ctrl: got %b exp 0000", {dmemRequest, stall, registerWriteEnableOut, faultOut}); end
    checks++; if (writeBackDataOut !== 32'h0 || rdOut !== 5'd0) begin errors++; $display("FAIL reset_data: got wb=%h rd=%0d exp 0/0", writeBackDataOut, rdOut); end
    @(negedge clock); reset = 1'b1;
    @(posedge clock); #1;
  endtask

  task automatic test_directed;
    run_mem("lw_wait3", 1, 0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 5'd7, 1, 1, 3);
    run_mem("lb_neg", 1, 0, 3'b000, 32'h103, 32'h0, 32'h80AABBCC, 5'd8, 1, 1, 0);
    run_mem("lbu", 1, 0, 3'b100, 32'h103, 32'h0, 32'h80AABBCC, 5'd9, 1, 1, 1);
    run_mem("lhu", 1, 0, 3'b101, 32'h102, 32'h0, 32'h80AABBCC, 5'd10, 1, 1, 0);
    run_mem("lh_neg", 1, 0, 3'b001, 32'h102, 32'h0, 32'h80AABBCC, 5'd11, 1, 1, 2);
    run_mem("sb", 0, 1, 3'b000, 32'h201, 32'h000000A5, 32'h0, 5'd12, 0, 1, 1);
    run_mem("sh", 0, 1, 3'b001, 32'h202, 32'h1234BEEF, 32'h0, 5'd13, 0, 1, 0);
    run_mem("sw_misaligned", 0, 1, 3'b010, 32'h202, 32'h11223344, 32'h0, 5'd14, 0, 1, 0);
    run_mem("lh_misaligned", 1, 0, 3'b001, 32'h101, 32'h0, 32'h0, 5'd15, 1, 1, 0);
    run_mem("both_enables", 1, 1, 3'b010, 32'h100, 32'h0, 32'h0, 5'd16, 1, 1, 0);
    run_mem("ld_func3_illegal", 1, 0, 3'b011, 32'h100, 32'h0, 32'h0, 5'd17, 1, 1, 0);
    run_mem("st_func3_illegal", 0, 1, 3'b100, 32'h100, 32'h0, 32'h0, 5'd18, 0, 1, 0);
    run_mem("lw_alu_path", 1, 0, 3'b010, 32'h344, 32'h0, 32'hCAFEF00D, 5'd19, 0, 1, 0);
  endtask

  task automatic test_timeout;
    run_mem("lw_timeout", 1, 0, 3'b010, 32'h400, 32'h0, 32'h0, 5'd3, 1, 1, TO);
    alu_op("after_timeout", 32'h0BAD_CAFE, 5'd4, 1);
  endtask

  task automatic test_alu_ops;
    alu_op("alu_rd0", 32'h5555_AAAA, 5'd0, 1);
    for (int i = 0; i < 6; i++) alu_op("alu_rand", $urandom, 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)));
  endtask

  task automatic test_back_to_back;
    alu_op("b2b_alu0", 32'h1111_0000, 5'd1, 1);
    run_mem("b2b_ld0", 1, 0, 3'b010, 32'h500, 32'h0, 32'h0102_0304, 5'd2, 1, 1, 0);
    run_mem("b2b_ld1", 1, 0, 3'b000, 32'h501, 32'h0, 32'h0102_0304, 5'd3, 1, 1, 0);
    alu_op("b2b_alu1", 32'h2222_0000, 5'd5, 1);
  endtask

  task automatic test_random;
    logic ld, st;
    logic [2:0] f3;
    int kind;
    for (int i = 0; i < 40; i++) begin
      kind = $urandom_range(0, 9);
      if (kind < 2) begin
        alu_op("rand_alu", $urandom, 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)));
      end else begin
        ld = (kind < 6) || (kind == 9);
        st = (kind >= 6);
        f3 = 3'($urandom_range(0, 7));
        run_mem("rand_mem", ld, st, f3, $urandom, $urandom, $urandom,
                5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                $urandom_range(0, TO + 1));
      end
    end
  endtask

  task automatic test_reset_mid_busy;
    alu_op("pre_reset_alu", 32'h1234_5678, 5'd21, 1);
    memoryReadEnable = 1'b1; memoryWriteEnable = 1'b0; func3 = 3'b010; alu = 32'h600;
    rd = 5'd22; registerWriteEnable = 1'b1; writeBackFromMemoryOrAlu = 1'b1; dmemReady = 1'b0;
    @(posedge clock); #1;
    @(posedge clock); #1;
    checks++; if (dmemRequest !== 1'b1) begin errors++; $display("FAIL midbusy_req_before: got %0b exp 1", dmemRequest); end
    #2 reset = 1'b0;
    #1;
    checks++; if (dmemRequest !== 1'b0 || stall !== 1'b0) begin errors++; $display("FAIL midbusy_reset_ctrl: got req=%0b stall=%0b exp 0/0", dmemRequest, stall); end
    checks++; if (writeBackDataOut !== 32'h0 || rdOut !== 5'd0 || registerWriteEnableOut !== 1'b0 || faultOut !== 1'b0) begin
      errors++; $display("FAIL midbusy_reset_regs: got wb=%h rd=%0d we=%0b fault=%0b exp zeros", writeBackDataOut, rdOut, registerWriteEnableOut, faultOut);
    end
    memoryReadEnable = 1'b0;
    @(negedge clock); reset = 1'b1;
    @(posedge clock); #1;
    alu_op("post_reset_alu", 32'h0F0F_0F0F, 5'd23, 1);
  endtask

  initial begin
    test_reset;
    test_directed;
    test_timeout;
    test_alu_ops;
    test_back_to_back;
    test_random;
    test_reset_mid_busy;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
